// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : requester-side and memory-side signals of mem_arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 7,
  parameter int DW   = 16
);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         we;
  logic [NREQ*AW-1:0]      addr;
  logic [NREQ*DW-1:0]      wdata;
  logic [NREQ-1:0]         ack;
  logic [DW-1:0]           rdata;
  logic                    mrd;
  logic                    mwr;
  logic [AW-1:0]           maddr;
  logic [DW-1:0]           mdo;
  logic [DW-1:0]           mdi;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] gnt_id;

  // Requesters plus the memory model drive this side.
  modport master (
    output req, we, addr, wdata, mdi,
    input  ack, rdata, mrd, mwr, maddr, mdo, busy, gnt_id
  );

  modport slave (
    input  req, we, addr, wdata, mdi,
    output ack, rdata, mrd, mwr, maddr, mdo, busy, gnt_id
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin arbiter serialising reads/writes onto one memory
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int NREQ   = 2,
  parameter int AW     = 7,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TURN  = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  logic [2:0]    state;
  logic [IW-1:0] last;
  logic          lastwr;
  logic [2:0]    cnt;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic          found;

  // Search starts one past the last winner and wraps modulo NREQ.
  always_comb begin
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last       <= IW'(NREQ - 1);
      lastwr     <= 1'b0;
      cnt        <= '0;
      bus.ack    <= '0;
      bus.rdata  <= '0;
      bus.mrd    <= 1'b0;
      bus.mwr    <= 1'b0;
      bus.maddr  <= '0;
      bus.mdo    <= '0;
      bus.busy   <= 1'b0;
      bus.gnt_id <= '0;
    end else begin
      bus.ack <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            bus.gnt_id <= win;
            last       <= win;
            bus.maddr  <= bus.addr[win*AW +: AW];
            bus.mdo    <= bus.wdata[win*DW +: DW];
            bus.busy   <= 1'b1;
            if (bus.we[win]) begin
              state   <= S_WR;
              bus.mwr <= 1'b1;
            end else if (lastwr) begin
              state <= S_TURN;
            end else begin
              state   <= S_RD;
              bus.mrd <= 1'b1;
            end
          end
        end
        S_TURN: begin
          state   <= S_RD;
          bus.mrd <= 1'b1;
        end
        S_RD: begin
          bus.mrd <= 1'b0;
          cnt     <= 3'(RD_LAT);
          state   <= S_RWAIT;
        end
        S_RWAIT: begin
          cnt <= cnt - 3'd1;
          // cnt reaches 1 in the cycle the memory presents read data.
          if (cnt == 3'd1) begin
            bus.rdata <= bus.mdi;
            lastwr    <= 1'b0;
            bus.ack   <= ONE_HOT0 << bus.gnt_id;
            state     <= S_DONE;
          end
        end
        S_WR: begin
          bus.mwr <= 1'b0;
          lastwr  <= 1'b1;
          bus.ack <= ONE_HOT0 << bus.gnt_id;
          state   <= S_DONE;
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.mrd  <= 1'b0;
          bus.mwr  <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   acks1  = 0;
  int   cyc    = 0;
  int   wr_cyc = 0;
  bit   prev_wr = 1'b0;
  bit   mrd_prev = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.NREQ(2), .AW(7), .DW(16)) b1 ();
  mem_arbiter_if #(.NREQ(2), .AW(7), .DW(16)) b3 ();

  mem_arbiter #(.NREQ(2), .AW(7), .DW(16), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.NREQ(2), .AW(7), .DW(16), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  // Memory models: unwritten words read back as 16'hC000 | address.
  logic [127:0] vld1;
  logic [15:0]  mem1 [128];
  logic [15:0]  p1;
  logic [15:0]  p3 [3];

  always @(posedge clk) begin
    if (rst) vld1 <= '0;
    else if (b1.mwr) begin
      mem1[b1.maddr] <= b1.mdo;
      vld1[b1.maddr] <= 1'b1;
    end
    p1 <= b1.mrd ? (vld1[b1.maddr] ? mem1[b1.maddr] : (16'hC000 | {9'd0, b1.maddr})) : 16'hBAD0;
    p3[0] <= b3.mrd ? (16'hC000 | {9'd0, b3.maddr}) : 16'hBAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.mdi = p1;
  assign b3.mdi = p3[2];

  // Strobe-protocol watch on the RD_LAT=1 instance.
  always @(negedge clk) begin
    cyc++;
    if (b1.mrd || b1.mwr) begin
      checks++;
      assert (!(b1.mrd && b1.mwr)) else begin
        errors++;
        $error("FAIL strobe_overlap observed=%0b%0b expected=not both", b1.mrd, b1.mwr);
      end
      if (b1.mrd) begin
        checks++;
        assert (!mrd_prev) else begin
          errors++;
          $error("FAIL mrd_width observed=2+ cycles expected=1 cycle");
        end
      end
      if (b1.mrd && prev_wr) begin
        checks++;
        assert ((cyc - wr_cyc) >= 4) else begin
          errors++;
          $error("FAIL turnaround_gap observed=%0d expected>=4", cyc - wr_cyc);
        end
      end
      prev_wr = b1.mwr;
      if (b1.mwr) wr_cyc = cyc;
    end
    mrd_prev = b1.mrd;
    if (b1.ack != 2'b00) acks1++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (b1.ack != 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit ok;
    b1.req = 2'b11; b1.we = 2'b00; b1.addr = {7'h11, 7'h10}; b1.wdata = '0;
    b3.req = 2'b00; b3.we = 2'b00; b3.addr = '0; b3.wdata = '0;

    // Reset held 3 cycles with both requests pending.
    repeat (3) tick();
    chk("rst_ack", b1.ack, 0);
    chk("rst_rdata", b1.rdata, 0);
    chk("rst_mrd", b1.mrd, 0);
    chk("rst_mwr", b1.mwr, 0);
    chk("rst_maddr", b1.maddr, 0);
    chk("rst_mdo", b1.mdo, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_gnt", b1.gnt_id, 0);

    // Simultaneous reads: requester 0 first, then 1.
    rst = 1'b0;
    tick();
    chk("sim0_mrd", b1.mrd, 1);
    chk("sim0_gnt", b1.gnt_id, 0);
    chk("sim0_maddr", b1.maddr, 7'h10);
    chk("sim0_busy", b1.busy, 1);
    tick();
    chk("sim0_mrd_low", b1.mrd, 0);
    tick();
    chk("sim0_ack", b1.ack, 2'b01);
    chk("sim0_rdata", b1.rdata, 16'hC010);
    b1.req = 2'b10;
    tick();
    chk("sim_idle_busy", b1.busy, 0);
    chk("sim_idle_ack", b1.ack, 0);
    tick();
    chk("sim1_mrd", b1.mrd, 1);
    chk("sim1_gnt", b1.gnt_id, 1);
    chk("sim1_maddr", b1.maddr, 7'h11);
    tick();
    tick();
    chk("sim1_ack", b1.ack, 2'b10);
    chk("sim1_rdata", b1.rdata, 16'hC011);
    b1.req = 2'b00;
    tick();
    chk("sim_busy_end", b1.busy, 0);
    chk("sim_ack_total", acks1, 2);

    // Single write by requester 0.
    b1.req = 2'b01; b1.we = 2'b01; b1.addr = {7'h05, 7'h05}; b1.wdata = {16'h0000, 16'hBEEF};
    tick();
    chk("wr_mwr", b1.mwr, 1);
    chk("wr_mrd", b1.mrd, 0);
    chk("wr_maddr", b1.maddr, 7'h05);
    chk("wr_mdo", b1.mdo, 16'hBEEF);
    chk("wr_gnt", b1.gnt_id, 0);
    b1.addr[6:0] = 7'h7F; b1.wdata[15:0] = 16'h0000;
    tick();
    chk("wr_ack", b1.ack, 2'b01);
    chk("wr_mwr_low", b1.mwr, 0);
    b1.req = 2'b10; b1.we = 2'b00;
    tick();
    chk("wr_mem05", mem1[5], 16'hBEEF);
    chk("wr_idle_busy", b1.busy, 0);

    // Read after write by requester 1: TURN first.
    tick();
    chk("raw_turn_busy", b1.busy, 1);
    chk("raw_turn_mrd", b1.mrd, 0);
    chk("raw_turn_mwr", b1.mwr, 0);
    chk("raw_gnt", b1.gnt_id, 1);
    tick();
    chk("raw_mrd", b1.mrd, 1);
    chk("raw_maddr", b1.maddr, 7'h05);
    tick();
    chk("raw_ack_early", b1.ack, 0);
    tick();
    chk("raw_ack", b1.ack, 2'b10);
    chk("raw_rdata", b1.rdata, 16'hBEEF);
    b1.req = 2'b00;
    tick();

    // Saturation: requester 0 writes, requester 1 reads the same word.
    b1.req = 2'b11; b1.we = 2'b01; b1.addr = {7'h20, 7'h20}; b1.wdata = {16'h0000, 16'hA000};
    for (int k = 0; k < 8; k++) begin
      wait_ack1(ok);
      chk("sat_ack_seen", 32'(ok), 1);
      chk("sat_gnt", b1.gnt_id, k % 2);
      chk("sat_ack", b1.ack, 2'b01 << (k % 2));
      if (k % 2 == 1) chk("sat_rdata", b1.rdata, 16'hA000 + (k - 1) / 2);
      else b1.wdata[15:0] = 16'(16'hA000 + k / 2 + 1);
      tick();
    end
    b1.req = 2'b00;
    tick();
    chk("sat_busy_end", b1.busy, 0);

    // Reset mid-read on the RD_LAT=3 instance.
    b3.req = 2'b01; b3.we = 2'b00; b3.addr = {7'h12, 7'h11};
    tick();
    chk("mr_mrd", b3.mrd, 1);
    chk("mr_maddr", b3.maddr, 7'h11);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mr_abort_ack", b3.ack, 0);
    chk("mr_abort_mrd", b3.mrd, 0);
    chk("mr_abort_busy", b3.busy, 0);
    rst = 1'b0;
    b3.req = 2'b10;
    tick();
    chk("mr1_mrd", b3.mrd, 1);
    chk("mr1_gnt", b3.gnt_id, 1);
    chk("mr1_maddr", b3.maddr, 7'h12);
    tick();
    tick();
    tick();
    chk("mr1_ack_early", b3.ack, 0);
    tick();
    chk("mr1_ack", b3.ack, 2'b10);
    chk("mr1_rdata", b3.rdata, 16'hC012);
    b3.req = 2'b00;
    tick();
    chk("mr1_busy_end", b3.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port test memory between NREQ independent requesters. Each requester is typically a controller block that today drives the memory strobes directly. The arbiter sits between the requesters and the memory interface. It serialises read and write transactions onto the MRD/MWR strobes and enforces a read-after-write turnaround cycle. It returns read data and a one-cycle acknowledge to the winning requester.

## Interface
- NREQ, 2: number of requesters (2..8).
- AW, 7: address width (128-word memory).
- DW, 16: data width.
- RD_LAT, 1: cycles from the MRD cycle until MDI is valid (1..4).

- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  NREQ  per-requester request; held high and stable until that requester's ACK.
- WE  in  NREQ  per-requester direction: 1 = write, 0 = read.
- ADDR  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- WDATA  in  NREQ*DW  flattened write data; same slicing as ADDR.
- ACK  out  NREQ  one-hot, one-cycle completion pulse.
- RDATA  out  DW  read data; valid only while the read's ACK bit is high.
- MRD  out  1  memory read strobe.
- MWR  out  1  memory write strobe.
- MADDR  out  AW  memory address.
- MDO  out  DW  memory write data.
- MDI  in  DW  memory read data.
- BUSY  out  1  high in every state except IDLE.
- GNT_ID  out  $clog2(NREQ)  index of the current or last granted requester.

## Operation
- All outputs are registered.
- Reset values: ACK=0, RDATA=0, MRD=0, MWR=0, MADDR=0, MDO=0, BUSY=0, GNT_ID=0.
- Reset also clears the internal state: state=IDLE, pointer LAST=NREQ-1 (so requester 0 wins first), LASTWR=0.
- States:
  - IDLE: sample REQ. If any bit is set, pick the winner: search from LAST+1 upward, wrapping modulo NREQ. Latch the winner's WE, ADDR and WDATA, and update GNT_ID and LAST. Go to WR if WE=1, to TURN if WE=0 and LASTWR=1, otherwise to RD.
  - TURN: single idle cycle with both strobes low; then RD.
  - RD: MRD=1 for exactly one cycle with MADDR valid; then RWAIT, with the counter loaded to RD_LAT.
  - RWAIT: decrement the counter each cycle. At the end of the cycle in which MDI is valid, register MDI into RDATA, set LASTWR=0 and go to DONE.
  - WR: MWR=1 for exactly one cycle with MADDR and MDO valid. Set LASTWR=1; then DONE.
  - DONE: ACK[GNT_ID]=1 for this cycle only; REQ is not sampled. Then IDLE.
- The latched request is immune to changes on ADDR, WDATA or WE after the grant.
- LAST changes only on a grant. An idle cycle with no requests does not change priority.
- MRD and MWR are never high in the same cycle. A write strobe is never followed by a read strobe without an intervening TURN cycle.
- Reset asserted in any state:
  - Aborts the transaction on the next edge; no ACK is issued for it.
  - Strobes drop to 0 at that edge.
  - A requester whose transaction was aborted must re-request.

## Timing
- Cycle 0 is the cycle in which IDLE samples REQ high.
- Write: MWR high in cycle 1, ACK in cycle 2, IDLE in cycle 3. That is 3 cycles per write.
- Read, no turnaround: MRD in cycle 1, MDI valid in cycle 1+RD_LAT, ACK and RDATA in cycle 2+RD_LAT.
- Read after a write: every event above is one cycle later.
- The requester drops REQ in the cycle after ACK. REQ still high in the first IDLE cycle after DONE is treated as a new request.
- Back-to-back grants: a new grant is possible in the cycle after DONE.
- Under saturation, with all requesters asserting REQ, grants rotate strictly i, i+1, ... modulo NREQ. No requester waits more than NREQ-1 transactions.

## Test plan
- Reset: hold RST 3 cycles with REQ=2'b11 -> all outputs 0, no strobes, BUSY=0; first grant after release is to requester 0.
- Single write: REQ[0], WE=1, ADDR=7'h05, WDATA=16'hBEEF -> MWR=1 with MADDR=05 and MDO=BEEF in cycle 1; ACK=2'b01 in cycle 2; memory word 05 = BEEF.
- Read after write: immediately after the previous write, REQ[1] reads 7'h05 (RD_LAT=1) -> TURN in cycle 1, MRD in cycle 2, ACK=2'b10 in cycle 4 with RDATA=16'hBEEF.
- Simultaneous requests after reset: REQ=2'b11, both reads -> requester 0 served first, then requester 1. Both MRD pulses are single-cycle, and 2 ACKs are received in total.
- Saturation: both requesters re-request continuously for 8 transactions with mixed WE -> GNT_ID sequence 0,1,0,1,0,1,0,1. A TURN cycle appears before every read that follows a write. MRD and MWR are never both high.
- Reset mid-read: with RD_LAT=3, assert RST during RWAIT -> no ACK, MRD=0, BUSY=0 next cycle. A subsequent REQ[1] alone is granted and completes normally.
